// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared encodings and types for the HI/LO multiply/divide unit.
// Funct values match the MIPS SPECIAL-opcode encodings.
package HiLoPkg;

    typedef logic [31:0] Word;
    typedef logic [63:0] DWord;

    localparam logic [5:0] OPC_SPECIAL = 6'b000000;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_e;

    // Two's-complement magnitude; 0x80000000 maps to unsigned 2^31.
    function automatic Word abs_word(input Word v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_muldiv_iter.sv
// Unsigned iterative datapath: shift-add multiply and restoring divide
// sharing one 64-bit shift register and a down-counting iteration timer.
module muldiv_iter
    import HiLoPkg::*;
#(
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    input  Word  op_a,
    input  Word  op_b,
    output DWord result,
    output logic done
);

    localparam int K = MUL_BITS_PER_CYCLE;
    localparam logic [5:0] MUL_ITERS = 6'(32 / K);
    localparam logic [5:0] DIV_ITERS = 6'd32;

    DWord       acc_q, acc_d;
    Word        opb_q, opb_d;
    logic [5:0] cnt_q, cnt_d;
    logic       div_q, div_d;

    logic [36:0] mul_sum;
    logic [68:0] mul_wide;
    DWord        mul_next;
    logic [32:0] rem_shift;
    logic        rem_ge;
    Word         rem_sub;
    DWord        div_next;

    always_comb begin
        // Upper half accumulates multiplicand * low K multiplier bits, then the pair shifts right by K.
        mul_sum   = {5'b0, acc_q[63:32]} + 37'(opb_q) * 37'(acc_q[K-1:0]);
        mul_wide  = {mul_sum, acc_q[31:0]};
        mul_next  = 64'(mul_wide >> K);

        rem_shift = acc_q[63:31];
        rem_ge    = (rem_shift >= {1'b0, opb_q});
        rem_sub   = rem_shift[31:0] - opb_q;
        div_next  = rem_ge ? {rem_sub, acc_q[30:0], 1'b1}
                           : {rem_shift[31:0], acc_q[30:0], 1'b0};
    end

    always_comb begin
        acc_d = acc_q;
        opb_d = opb_q;
        cnt_d = cnt_q;
        div_d = div_q;
        if (start) begin
            acc_d = {32'b0, op_a};
            opb_d = op_b;
            div_d = is_div;
            cnt_d = is_div ? DIV_ITERS : MUL_ITERS;
        end else if (cnt_q != 6'd0) begin
            acc_d = div_q ? div_next : mul_next;
            cnt_d = cnt_q - 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            opb_q <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            opb_q <= opb_d;
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

    assign result = acc_q;
    assign done   = (cnt_q == 6'd1);

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO execution unit: decodes SPECIAL mult/div/mt*/mf* words, owns HI/LO,
// sign handling and the issue interlock around the iterative datapath.
//
// state | meaning
// IDLE  | ready to accept; mt*/mf* complete in one edge
// MUL   | multiply iterations in flight
// DIV   | divide iterations in flight
// FIX   | sign correction and HI/LO write
module hilo_muldiv_unit
    import HiLoPkg::*;
#(
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e     state_q, state_d;
    Word        hi_q, hi_d, lo_q, lo_d;
    logic       out_valid_q, out_valid_d;
    Word        out_data_q, out_data_d;
    logic [4:0] out_rd_q, out_rd_d;
    logic       neg_res_q, neg_res_d;
    logic       neg_rem_q, neg_rem_d;
    logic       div_zero_q, div_zero_d;
    logic       op_div_q, op_div_d;
    Word        dividend_q, dividend_d;

    logic [5:0] funct;
    logic       is_special, accept, dec_mul, dec_div, dec_signed;
    Word        mag_a, mag_b;
    DWord       iter_result, prod_fix;
    Word        quot_fix, rem_fix;
    logic       iter_done;
    logic       unused_instr_bits;

    assign funct      = instr[5:0];
    assign is_special = (instr[31:26] == OPC_SPECIAL);
    assign accept     = in_valid && (state_q == IDLE);
    assign dec_mul    = is_special && (funct == F_MULT || funct == F_MULTU);
    assign dec_div    = is_special && (funct == F_DIV  || funct == F_DIVU);
    assign dec_signed = (funct == F_MULT) || (funct == F_DIV);
    assign mag_a      = dec_signed ? abs_word(rs_val) : rs_val;
    assign mag_b      = dec_signed ? abs_word(rt_val) : rt_val;
    assign unused_instr_bits = ^{instr[25:16], instr[10:6]};

    muldiv_iter #(
        .MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)
    ) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (accept && (dec_mul || dec_div)),
        .is_div (dec_div),
        .op_a   (mag_a),
        .op_b   (mag_b),
        .result (iter_result),
        .done   (iter_done)
    );

    assign prod_fix = neg_res_q ? (~iter_result + 64'd1) : iter_result;
    assign quot_fix = neg_res_q ? (~iter_result[31:0] + 32'd1) : iter_result[31:0];
    assign rem_fix  = neg_rem_q ? (~iter_result[63:32] + 32'd1) : iter_result[63:32];

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
        div_zero_d  = div_zero_q;
        op_div_d    = op_div_q;
        dividend_d  = dividend_q;
        unique case (state_q)
            IDLE: begin
                if (accept && is_special) begin
                    unique case (funct)
                        F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                            state_d    = dec_div ? DIV : MUL;
                            op_div_d   = dec_div;
                            neg_res_d  = dec_signed && (rs_val[31] ^ rt_val[31]);
                            neg_rem_d  = dec_signed && rs_val[31];
                            div_zero_d = (rt_val == 32'd0);
                            dividend_d = rs_val;
                        end
                        F_MTHI: hi_d = rs_val;
                        F_MTLO: lo_d = rs_val;
                        F_MFHI, F_MFLO: begin
                            out_valid_d = 1'b1;
                            out_data_d  = (funct == F_MFHI) ? hi_q : lo_q;
                            out_rd_d    = instr[15:11];
                        end
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                if (iter_done) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                if (!op_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (div_zero_q) begin
                    lo_d = 32'hFFFF_FFFF;
                    hi_d = dividend_q;
                end else begin
                    lo_d = quot_fix;
                    hi_d = rem_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            op_div_q    <= 1'b0;
            dividend_q  <= '0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            neg_res_q   <= neg_res_d;
            neg_rem_q   <= neg_rem_d;
            div_zero_q  <= div_zero_d;
            op_div_q    <= op_div_d;
            dividend_q  <= dividend_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_rd    = out_rd_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule
